seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Consumes the divided clock from the universal clock divider (e.g. 1 kHz from 1 MHz) as a scan-rate strobe.
- Time-multiplexes a common-anode multi-digit 7-segment display from a packed hex value.
- Runs entirely in the clk_in domain. The divided clock is sampled as data and edge-detected; it is never used as a clock.

Parameters:
- DIGITS, 4, number of display digits (1..8).
- BLANK_LZ, 1, 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk_in  input  1  system clock (same clock that feeds the divider).
- rst  input  1  synchronous, active-high reset.
- clk_div  input  1  divided clock from the divider; sampled as a level.
- en  input  1  display enable; 0 = all digits off, scan index holds.
- value  input  4*DIGITS  packed hex nibbles; nibble i drives digit i.
- dp_mask  input  DIGITS  decimal point request per digit (1 = lit).
- an  output  DIGITS  digit enables, active-low (one-hot-low when lit).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (synchronous, rst=1 at a clk_in edge):
  - an = all 1s, seg = 7'h7F, dp = 1.
  - Scan index = 0; sync/edge flops = 0; snapshot registers = 0.
  - Reset has priority over every other input. Reset mid-frame aborts the frame; the next tick after release displays digit 0.
- Edge detect:
  - 3-flop shift sync[2:0] <= {sync[1:0], clk_div}.
  - tick = sync[1] & ~sync[2], a single clk_in-cycle pulse per clk_div rising edge.
  - Falling edges are ignored.
  - If clk_div is held constant, no ticks occur and the outputs hold.
- Latency: the first clk_in edge sampling clk_div=1 is E0. tick is high between E1 and E2. an/seg/dp update at E2.
- Scan index:
  - On tick with en=1: idx <= (idx == DIGITS-1) ? 0 : idx+1.
  - Displayed digit = the index value after the update. The first tick after reset therefore shows digit 1.
  - Exception: a "fresh" flag, set by reset, makes the first tick show digit 0 and clears the flag instead of incrementing.
- Snapshot:
  - value and dp_mask are copied into snap registers on any tick where the displayed digit becomes 0.
  - This gives frame-coherent display. Changes to value mid-frame appear only from the next frame.
- Output, registered and updated only on ticks with en=1:
  - an = ~(1 << idx).
  - seg = decode(snap nibble idx), or 7'h7F if blanked.
  - dp = ~snap_dp[idx].
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is blanked when snap nibbles i..DIGITS-1 are all 0. A blanked digit keeps its anode active with seg=7'h7F; dp still follows the mask.
- Decode table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- en=0:
  - At the next clk_in edge an = all 1s, seg = 7'h7F, dp = 1, independent of tick.
  - idx and snap hold.
  - On en returning to 1, the next tick resumes at idx+1.
- Simultaneous events:
  - tick with en=0: no index advance.
  - tick with rst: reset wins.
  - tick on the wrap cycle: snapshot and output use the newly captured value in the same update. The decode reads the incoming value directly when the snapshot is being loaded.

Decomposition:
- Shared header seg_defs.vh holds:
  - the 16 hex segment constants (SEG_0..SEG_F);
  - SEG_BLANK = 7'h7F;
  - the DIGITS max.
- Sub-module hex7seg_dec: purely combinational nibble -> 7-bit active-low pattern. It is reused by the later scoreboard/stopwatch blocks.
- Edge detect and scan/snapshot logic stay inline.

Test Plan:
1. Reset release, value=16'h12A0, dp_mask=0, clk_div toggling every 10 clk_in cycles -> first update shows an=4'b1110, seg=7'b1000000. Subsequent ticks show:
   - an=1101, seg=0001000 (A)
   - an=1011, seg=0100100 (2)
   - an=0111, seg=1111001 (1)
   - then back to an=1110.
2. Latency: clk_div rises just before edge E0 -> an/seg change exactly at E2 and tick lasts exactly 1 cycle. Holding clk_div=1 for 50 cycles produces no further updates.
3. Blanking: value=16'h0005, BLANK_LZ=1 -> digit0 seg=0010010; digits 1..3 seg=7'h7F with their anodes low. With value=0 only digit0 shows 0.
4. Frame coherence: value changes 16'h1111 -> 16'h2222 while idx=1 -> digits 2,3 still show 1111001. The next frame shows 0100100 on all digits.
5. en=0 mid-frame at idx=2 -> next edge an=4'hF, seg=7'h7F, dp=1. Ticks are ignored; en=1 then the next tick shows idx=3.
6. rst asserted coincident with a tick at idx=2 -> outputs reset values. The first tick after release shows digit 0. dp_mask=4'b0100 lights dp=0 only while an=1011.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared segment constants and sizing helpers for the 7-segment scan driver
//
// Contents:
//   DIGITS_MAX     largest supported digit count
//   SEG_0..SEG_F   active-low {g,f,e,d,c,b,a} patterns for hex digits
//   SEG_BLANK      all segments off
//   idx_width()    width of a scan index for a given digit count (min 1)

package seg_scan_driver_pkg;

    localparam int DIGITS_MAX = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // A single-digit display still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - display pin bundle (anodes, segments, decimal point)
//
// Signals (all active-low):
//   an   [DIGITS-1:0]  digit anode enables
//   seg  [6:0]         segments {g,f,e,d,c,b,a}
//   dp                 decimal point
// Modports:
//   master  the driver producing the pins
//   slave   the display / observer consuming them

interface seg_scan_driver_if #(
    parameter int DIGITS = 4
) ();
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;

    modport master (output an, output seg, output dp);
    modport slave  (input an, input seg, input dp);
endinterface

// File: rtl/seg_scan_driver_hex7seg_dec.sv
// rtl/seg_scan_driver_hex7seg_dec.sv - combinational hex nibble to active-low 7-segment pattern
//
// Ports:
//   nibble  in   4  hex value 0..F
//   seg     out  7  active-low {g,f,e,d,c,b,a}

module hex7seg_dec
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed common-anode 7-segment driver strobed by a divided clock
//
// Parameters:
//   DIGITS    number of digits (1..8)
//   BLANK_LZ  1 = blank leading zero digits (digit 0 never blanked)
// Ports:
//   clk_in   in   1         system clock
//   rst      in   1         synchronous active-high reset
//   clk_div  in   1         divided clock, sampled as data (scan strobe)
//   en       in   1         display enable; 0 = dark, scan index holds
//   value    in   4*DIGITS  packed hex nibbles, nibble i -> digit i
//   dp_mask  in   DIGITS    decimal point request per digit, 1 = lit
//   disp     master         an / seg / dp, all active-low, registered

module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  clk_div,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    seg_scan_driver_if.master     disp
);

    localparam int               IDX_W    = idx_width(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [2:0]          sync;
    logic                tick;

    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    next_idx;
    logic                fresh;
    logic [4*DIGITS-1:0] snap_val;
    logic [DIGITS-1:0]   snap_dp;

    logic                load;
    logic [4*DIGITS-1:0] eff_val;
    logic [DIGITS-1:0]   eff_dp;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                upper_nz;
    logic                blank;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   an_next;

    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;
    logic                dp_q;

    // clk_div is asynchronous data here; sync[0] absorbs metastability,
    // sync[1]/sync[2] form the rising-edge detector.
    assign tick = sync[1] & ~sync[2];

    // After reset the first strobe shows digit 0 instead of advancing.
    always_comb begin
        next_idx = '0;
        if (fresh) begin
            next_idx = '0;
        end else if (idx == LAST_IDX) begin
            next_idx = '0;
        end else begin
            next_idx = idx + 1'b1;
        end
    end

    // Entering digit 0 starts a new frame: latch value/dp_mask so the
    // whole frame shows one coherent number. On that same update the
    // incoming value is used directly, since the snapshot is not yet loaded.
    assign load    = (next_idx == '0);
    assign eff_val = load ? value   : snap_val;
    assign eff_dp  = load ? dp_mask : snap_dp;

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        upper_nz = 1'b0;
        an_next  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == next_idx) begin
                cur_nib    = eff_val[4*i +: 4];
                cur_dp     = eff_dp[i];
                an_next[i] = 1'b0;
            end
            // Any nonzero nibble at or above the shown digit keeps it lit.
            if ((IDX_W'(i) >= next_idx) && (eff_val[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
    end

    assign blank = BLANK_LZ && (next_idx != '0) && !upper_nz;

    hex7seg_dec u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync     <= 3'b000;
            idx      <= '0;
            fresh    <= 1'b1;
            snap_val <= '0;
            snap_dp  <= '0;
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
        end else begin
            sync <= {sync[1:0], clk_div};
            if (!en) begin
                an_q  <= '1;
                seg_q <= SEG_BLANK;
                dp_q  <= 1'b1;
            end else if (tick) begin
                idx   <= next_idx;
                fresh <= 1'b0;
                if (load) begin
                    snap_val <= value;
                    snap_dp  <= dp_mask;
                end
                an_q  <= an_next;
                seg_q <= blank ? SEG_BLANK : dec_seg;
                dp_q  <= ~cur_dp;
            end
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed scoreboard bench for seg_scan_driver

module tb_seg_scan_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] DA = 7'b0001000;
    localparam logic [6:0] BL = 7'h7F;
    localparam exp_t       OFF = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

    logic        clk_in;
    logic        rst;
    logic        clk_div;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp_mask;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];
    exp_t cur;

    seg_scan_driver_if #(.DIGITS(4)) disp_if ();

    seg_scan_driver #(
        .DIGITS   (4),
        .BLANK_LZ (1'b1)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .clk_div (clk_div),
        .en      (en),
        .value   (value),
        .dp_mask (dp_mask),
        .disp    (disp_if)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.dp  = d;
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.an  = disp_if.an;
        o.seg = disp_if.seg;
        o.dp  = disp_if.dp;
        return o;
    endfunction

    task automatic chk(input string tag, input exp_t o, input exp_t e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   tag, o.an, o.seg, o.dp, e.an, e.seg, e.dp);
        end
    endtask

    // One clk_div rising edge: E0 is the first posedge seeing clk_div=1,
    // outputs must still be old after E1 and new after E2.
    task automatic do_tick(input string tag, input exp_t e, input int hold);
        exp_t x;
        sb_q.push_back(e);
        @(negedge clk_in) clk_div = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        #1 chk({tag, "_pre"}, obs(), cur);
        @(posedge clk_in);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            x = sb_q.pop_front();
            chk(tag, obs(), x);
            cur = x;
        end
        repeat (hold) @(posedge clk_in);
        #1 chk({tag, "_hold"}, obs(), cur);
        @(negedge clk_in) clk_div = 1'b0;
        repeat (5) @(posedge clk_in);
    endtask

    initial begin
        rst     = 1'b1;
        clk_div = 1'b0;
        en      = 1'b1;
        value   = 16'h12A0;
        dp_mask = 4'b0000;
        cur     = OFF;
        repeat (3) @(posedge clk_in);
        #1 chk("reset", obs(), OFF);
        @(negedge clk_in) rst = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 chk("idle_after_reset", obs(), OFF);

        // Scan order of 12A0, first tick shows digit 0
        do_tick("t1_d0", mk(4'b1110, D0, 1'b1), 4);
        do_tick("t1_d1", mk(4'b1101, DA, 1'b1), 4);
        do_tick("t1_d2", mk(4'b1011, D2, 1'b1), 4);
        do_tick("t1_d3", mk(4'b0111, D1, 1'b1), 4);
        do_tick("t1_wrap", mk(4'b1110, D0, 1'b1), 4);

        // clk_div held high for 50 cycles must not retrigger
        do_tick("t2_hold50", mk(4'b1101, DA, 1'b1), 50);
        do_tick("t2_d2", mk(4'b1011, D2, 1'b1), 4);
        do_tick("t2_d3", mk(4'b0111, D1, 1'b1), 4);

        // Leading-zero blanking
        value = 16'h0005;
        do_tick("t3_5_d0", mk(4'b1110, D5, 1'b1), 4);
        do_tick("t3_5_d1", mk(4'b1101, BL, 1'b1), 4);
        do_tick("t3_5_d2", mk(4'b1011, BL, 1'b1), 4);
        do_tick("t3_5_d3", mk(4'b0111, BL, 1'b1), 4);
        value = 16'h0000;
        do_tick("t3_0_d0", mk(4'b1110, D0, 1'b1), 4);
        do_tick("t3_0_d1", mk(4'b1101, BL, 1'b1), 4);
        do_tick("t3_0_d2", mk(4'b1011, BL, 1'b1), 4);
        do_tick("t3_0_d3", mk(4'b0111, BL, 1'b1), 4);

        // Frame coherence: change value while idx=1
        value = 16'h1111;
        do_tick("t4_d0", mk(4'b1110, D1, 1'b1), 4);
        do_tick("t4_d1", mk(4'b1101, D1, 1'b1), 4);
        value = 16'h2222;
        do_tick("t4_old_d2", mk(4'b1011, D1, 1'b1), 4);
        do_tick("t4_old_d3", mk(4'b0111, D1, 1'b1), 4);
        do_tick("t4_new_d0", mk(4'b1110, D2, 1'b1), 4);
        do_tick("t4_new_d1", mk(4'b1101, D2, 1'b1), 4);
        do_tick("t4_new_d2", mk(4'b1011, D2, 1'b1), 4);

        // Enable off at idx=2
        @(negedge clk_in) en = 1'b0;
        @(posedge clk_in);
        #1 chk("t5_en_off", obs(), OFF);
        cur = OFF;
        do_tick("t5_ignored", OFF, 4);
        @(negedge clk_in) en = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 chk("t5_en_on_no_tick", obs(), OFF);
        do_tick("t5_resume_d3", mk(4'b0111, D2, 1'b1), 4);

        // Reset coincident with a tick at idx=2
        do_tick("t6_d0", mk(4'b1110, D2, 1'b1), 4);
        do_tick("t6_d1", mk(4'b1101, D2, 1'b1), 4);
        do_tick("t6_d2", mk(4'b1011, D2, 1'b1), 4);
        @(negedge clk_in) clk_div = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        rst     = 1'b1;
        clk_div = 1'b0;
        @(posedge clk_in);
        #1 chk("t6_rst_tick", obs(), OFF);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst     = 1'b0;
        dp_mask = 4'b0100;
        cur     = OFF;
        repeat (5) @(posedge clk_in);
        #1 chk("t6_post_rst_idle", obs(), OFF);
        do_tick("t6_first_d0", mk(4'b1110, D2, 1'b1), 4);
        do_tick("t6_dp_d1", mk(4'b1101, D2, 1'b1), 4);
        do_tick("t6_dp_d2", mk(4'b1011, D2, 1'b0), 4);
        do_tick("t6_dp_d3", mk(4'b0111, D2, 1'b1), 4);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
